// File: rtl/regfile_write_sched_if.sv
// Writeback request, reservation and register-file write bundle for regfile_write_sched.
// master = writeback sources/decode side, slave = the scheduler.
interface regfile_write_sched_if #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 32,
    parameter int AW    = 5
);
    logic [NREQ-1:0]       Req_valid;
    logic [NREQ-1:0]       Req_ready;
    logic [NREQ*AW-1:0]    Req_addr;
    logic [NREQ*WIDTH-1:0] Req_data;
    logic                  Reserve_valid;
    logic [AW-1:0]         Reserve_addr;
    logic [WIDTH-1:0]      WriteData;
    logic [AW-1:0]         WriteRegister;
    logic                  RegWrite;
    logic [(1<<AW)-1:0]    Busy;
    logic                  Err;

    modport master (
        output Req_valid, Req_addr, Req_data, Reserve_valid, Reserve_addr,
        input  Req_ready, WriteData, WriteRegister, RegWrite, Busy, Err
    );

    modport slave (
        input  Req_valid, Req_addr, Req_data, Reserve_valid, Reserve_addr,
        output Req_ready, WriteData, WriteRegister, RegWrite, Busy, Err
    );
endinterface

// File: rtl/regfile_write_sched.sv
// Round-robin write-port scheduler with per-register busy scoreboard; one registered stage,
// RegWrite one cycle after the grant. Requesters are backpressured only by losing arbitration.
module regfile_write_sched #(
    parameter int NREQ  = 3,
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input logic                 Clk,
    input logic                 Reset_n,
    regfile_write_sched_if.slave bus
);
    localparam int NREG = 1 << AW;
    localparam int LGW  = $clog2(NREQ);

    logic [LGW-1:0]   last_grant;
    logic [NREQ-1:0]  grant;
    logic [LGW-1:0]   grant_idx;
    logic             found;
    int               cand;
    logic             xfer;
    logic [AW-1:0]    xfer_addr;
    logic [WIDTH-1:0] xfer_data;

    logic             wr_en_q;
    logic [AW-1:0]    wr_reg_q;
    logic [WIDTH-1:0] wr_dat_q;

    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_nxt;
    logic [NREG-1:0]  set_vec;
    logic [NREG-1:0]  clr_vec;
    logic             err_q;
    logic             err_nxt;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant     = '0;
        grant_idx = last_grant;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(last_grant) + 1 + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && bus.Req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = LGW'(cand);
            end
        end
        if (!Reset_n) grant = '0;
    end

    assign xfer      = |grant;
    assign xfer_addr = bus.Req_addr[grant_idx*AW +: AW];
    assign xfer_data = bus.Req_data[grant_idx*WIDTH +: WIDTH];

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            last_grant <= LGW'(NREQ - 1);
            wr_en_q    <= 1'b0;
            wr_reg_q   <= '0;
            wr_dat_q   <= '0;
        end else begin
            wr_en_q <= xfer && (xfer_addr != '0);
            if (xfer) last_grant <= grant_idx;
            if (xfer && (xfer_addr != '0)) begin
                wr_reg_q <= xfer_addr;
                wr_dat_q <= xfer_data;
            end
        end
    end

    // A reservation landing on the same edge as the retiring write wins: it is the younger one.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (bus.Reserve_valid && (bus.Reserve_addr != '0)) set_vec[bus.Reserve_addr] = 1'b1;
        if (wr_en_q) clr_vec[wr_reg_q] = 1'b1;
        busy_nxt    = (busy_q & ~clr_vec) | set_vec;
        busy_nxt[0] = 1'b0;

        err_nxt = err_q;
        if (|(set_vec & busy_q & ~clr_vec)) err_nxt = 1'b1;
        if (xfer && (xfer_addr != '0) && !busy_q[xfer_addr]) err_nxt = 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            err_q  <= err_nxt;
        end
    end

    assign bus.Req_ready     = grant;
    assign bus.RegWrite      = wr_en_q;
    assign bus.WriteRegister = wr_reg_q;
    assign bus.WriteData     = wr_dat_q;
    assign bus.Busy          = busy_q;
    assign bus.Err           = err_q;
endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: reset, handshake, round-robin, r0, scoreboard, throughput.
module tb_regfile_write_sched;
    logic Clk = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;

    regfile_write_sched_if #(.NREQ(3), .WIDTH(32), .AW(5)) bus ();

    regfile_write_sched #(.NREQ(3), .WIDTH(32), .AW(5)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [2:0] rr_exp [6];
    logic [2:0] rr2_exp [4];

    initial begin
        rr_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        rr2_exp = '{3'b001, 3'b100, 3'b001, 3'b100};

        Reset_n           = 1'b0;
        bus.Req_valid     = 3'b111;
        bus.Req_addr      = '0;
        bus.Req_data      = '0;
        bus.Reserve_valid = 1'b0;
        bus.Reserve_addr  = '0;
        tick();
        tick();
        chk("rst_ready", bus.Req_ready, 32'h0);
        chk("rst_regwrite", bus.RegWrite, 32'h0);
        chk("rst_wreg", bus.WriteRegister, 32'h0);
        chk("rst_wdata", bus.WriteData, 32'h0);
        chk("rst_busy", bus.Busy, 32'h0);
        chk("rst_err", bus.Err, 32'h0);
        bus.Req_valid = 3'b000;
        Reset_n       = 1'b1;

        // Single request from req1 to r5, reserved first
        bus.Reserve_valid = 1'b1;
        bus.Reserve_addr  = 5'd5;
        tick();
        bus.Reserve_valid = 1'b0;
        chk("single_busy_set", bus.Busy, 32'h0000_0020);
        bus.Req_addr[5 +: 5]   = 5'd5;
        bus.Req_data[32 +: 32] = 32'hDEADBEEF;
        bus.Req_valid          = 3'b010;
        #1;
        chk("single_ready", bus.Req_ready, 32'h2);
        tick();
        bus.Req_valid = 3'b000;
        chk("single_regwrite", bus.RegWrite, 32'h1);
        chk("single_wreg", bus.WriteRegister, 32'h5);
        chk("single_wdata", bus.WriteData, 32'hDEADBEEF);
        chk("single_busy_hold", bus.Busy, 32'h0000_0020);
        tick();
        chk("single_regwrite_off", bus.RegWrite, 32'h0);
        chk("single_busy_clr", bus.Busy, 32'h0);
        chk("single_wreg_hold", bus.WriteRegister, 32'h5);
        chk("single_err", bus.Err, 32'h0);

        // Round-robin from reset, all to r0 so the scoreboard stays quiet
        Reset_n = 1'b0;
        tick();
        Reset_n       = 1'b1;
        bus.Req_addr  = '0;
        bus.Req_data  = '0;
        bus.Req_valid = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_grant%0d", i), bus.Req_ready, 32'(rr_exp[i]));
            tick();
        end
        bus.Req_valid = 3'b101;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_skip_grant%0d", i), bus.Req_ready, 32'(rr2_exp[i]));
            tick();
        end
        bus.Req_valid = 3'b000;
        chk("rr_err", bus.Err, 32'h0);

        // r0 discard: last_grant is 2, req0 alone wins
        bus.Req_addr[0 +: 5]  = 5'd0;
        bus.Req_data[0 +: 32] = 32'h0000_1234;
        bus.Req_valid         = 3'b001;
        #1;
        chk("r0_ready", bus.Req_ready, 32'h1);
        tick();
        bus.Req_valid = 3'b000;
        chk("r0_regwrite", bus.RegWrite, 32'h0);
        chk("r0_wreg", bus.WriteRegister, 32'h0);
        chk("r0_wdata", bus.WriteData, 32'h0);
        chk("r0_err", bus.Err, 32'h0);

        // Scoreboard collision on r7
        bus.Reserve_valid = 1'b1;
        bus.Reserve_addr  = 5'd7;
        tick();
        bus.Reserve_valid     = 1'b0;
        bus.Req_addr[0 +: 5]  = 5'd7;
        bus.Req_data[0 +: 32] = 32'h0000_A5A5;
        bus.Req_valid         = 3'b001;
        tick();
        bus.Req_valid = 3'b000;
        chk("coll_regwrite", bus.RegWrite, 32'h1);
        chk("coll_wreg", bus.WriteRegister, 32'h7);
        bus.Reserve_valid = 1'b1;
        bus.Reserve_addr  = 5'd7;
        tick();
        chk("coll_busy_set_wins", bus.Busy, 32'h0000_0080);
        chk("coll_err_clean", bus.Err, 32'h0);
        tick();
        bus.Reserve_valid = 1'b0;
        chk("coll_err_double", bus.Err, 32'h1);
        tick();
        chk("coll_err_sticky", bus.Err, 32'h1);
        chk("coll_busy_hold", bus.Busy, 32'h0000_0080);

        // Reset while a write is in the output stage
        Reset_n = 1'b0;
        tick();
        Reset_n           = 1'b1;
        bus.Reserve_valid = 1'b1;
        bus.Reserve_addr  = 5'd9;
        tick();
        bus.Reserve_valid      = 1'b0;
        bus.Req_addr[5 +: 5]   = 5'd9;
        bus.Req_data[32 +: 32] = 32'h0000_0099;
        bus.Req_valid          = 3'b010;
        #1;
        chk("midrst_ready", bus.Req_ready, 32'h2);
        tick();
        bus.Req_valid = 3'b000;
        chk("midrst_regwrite_pre", bus.RegWrite, 32'h1);
        Reset_n = 1'b0;
        tick();
        chk("midrst_regwrite", bus.RegWrite, 32'h0);
        chk("midrst_busy", bus.Busy, 32'h0);
        chk("midrst_wreg", bus.WriteRegister, 32'h0);
        Reset_n       = 1'b1;
        bus.Req_addr  = '0;
        bus.Req_valid = 3'b111;
        #1;
        chk("midrst_first_grant", bus.Req_ready, 32'h1);
        tick();
        bus.Req_valid = 3'b000;

        // Back-to-back throughput from req2 to r1..r8
        bus.Reserve_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.Reserve_addr = 5'(i);
            tick();
        end
        bus.Reserve_valid = 1'b0;
        chk("tp_busy_set", bus.Busy, 32'h0000_01FE);
        for (int i = 1; i <= 8; i++) begin
            bus.Req_addr[10 +: 5]  = 5'(i);
            bus.Req_data[64 +: 32] = 32'h100 + 32'(i);
            bus.Req_valid          = 3'b100;
            #1;
            chk($sformatf("tp_ready%0d", i), bus.Req_ready, 32'h4);
            tick();
            chk($sformatf("tp_regwrite%0d", i), bus.RegWrite, 32'h1);
            chk($sformatf("tp_wreg%0d", i), bus.WriteRegister, 32'(i));
            chk($sformatf("tp_wdata%0d", i), bus.WriteData, 32'h100 + 32'(i));
        end
        bus.Req_valid = 3'b000;
        tick();
        chk("tp_regwrite_off", bus.RegWrite, 32'h0);
        chk("tp_busy_clr", bus.Busy, 32'h0);
        chk("tp_err", bus.Err, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
